// File: rtl/qlal3_a2f_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : qlal3_a2f_pkg
//  Description : Shared types and constants for the A2F register-bus
//                responder: FSM state encoding, fixed register addresses,
//                status-word bit positions and the control soft-clear bit.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package qlal3_a2f_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT    = 2'd1,
      ST_ACK     = 2'd2,
      ST_RELEASE = 2'd3
   } state_t;

   localparam logic [7:0] ADDR_GP_IN  = 8'd0;
   localparam logic [7:0] ADDR_GP_OUT = 8'd1;

   // A2F_Status = {busy, err_sticky, txn_cnt[4:0]}
   localparam int STATUS_BUSY_BIT = 6;
   localparam int STATUS_ERR_BIT  = 5;
   localparam int STATUS_CNT_MSB  = 4;
   localparam int STATUS_CNT_LSB  = 0;
   localparam int TXN_CNT_W       = 5;

   localparam int CTRL_SOFT_CLR_BIT = 7;

endpackage
`default_nettype wire

// File: rtl/qlal3_a2f_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : qlal3_a2f_responder_if
//  Description : A2F register-bus bundle between the ASSP initiator and the
//                fabric responder.
//  Ports       : master modport - drives REQ/RWn/ADDR/WR_DATA/Control/GP_OUT,
//                                 observes ACK/RD_DATA/Status/GP_IN
//                slave modport  - the mirror image
//  Revision    : 1.0  initial release
// ============================================================================
interface qlal3_a2f_responder_if ();

   logic       A2F_REQ;
   logic       A2F_RWn;
   logic [7:0] A2F_ADDR;
   logic [7:0] A2F_WR_DATA;
   logic [7:0] A2F_Control;
   logic [7:0] A2F_GP_OUT;
   logic       A2F_ACK;
   logic [7:0] A2F_RD_DATA;
   logic [6:0] A2F_Status;
   logic [7:0] A2F_GP_IN;

   modport master (
      output A2F_REQ, A2F_RWn, A2F_ADDR, A2F_WR_DATA, A2F_Control, A2F_GP_OUT,
      input  A2F_ACK, A2F_RD_DATA, A2F_Status, A2F_GP_IN
   );

   modport slave (
      input  A2F_REQ, A2F_RWn, A2F_ADDR, A2F_WR_DATA, A2F_Control, A2F_GP_OUT,
      output A2F_ACK, A2F_RD_DATA, A2F_Status, A2F_GP_IN
   );

endinterface
`default_nettype wire

// File: rtl/qlal3_a2f_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : qlal3_a2f_regfile
//  Description : 8-bit register file for the A2F responder. Slot 0 is the
//                GP_IN register, slot 1 a free-running snapshot of GP_OUT
//                (not writable), remaining slots are scratch.
//  Ports       : clk, rst           - clock, synchronous active-high reset
//                wr_en/addr/wr_data - write port (commit on clk edge)
//                gp_out             - sampled into slot 1 every cycle
//                rd_data            - combinational read of addr
//                unmapped           - addr >= NUM_REGS
//                gp_in              - slot 0 contents
//                regs_flat          - all slots, slot i at [8*i +: 8]
//  Revision    : 1.0  initial release
// ============================================================================
module qlal3_a2f_regfile
   import qlal3_a2f_pkg::*;
#(
   parameter int         NUM_REGS    = 8,
   parameter logic [7:0] UNMAPPED_RD = 8'hEE
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [7:0]            addr,
   input  logic [7:0]            wr_data,
   input  logic [7:0]            gp_out,
   output logic [7:0]            rd_data,
   output logic                  unmapped,
   output logic [7:0]            gp_in,
   output logic [NUM_REGS*8-1:0] regs_flat
);

   assign unmapped = ({24'd0, addr} >= 32'(NUM_REGS));
   assign gp_in    = regs_flat[8*int'(ADDR_GP_IN) +: 8];

   for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
      logic [7:0] r_q;

      if (i == int'(ADDR_GP_OUT)) begin : g_snapshot
         // Read-only mirror; write strobes to this slot are simply ignored.
         always_ff @(posedge clk) begin
            if (rst) r_q <= 8'h00;
            else     r_q <= gp_out;
         end
      end else begin : g_rw
         always_ff @(posedge clk) begin
            if (rst)
               r_q <= 8'h00;
            else if (wr_en && !unmapped && (addr == 8'(i)))
               r_q <= wr_data;
         end
      end

      assign regs_flat[8*i +: 8] = r_q;
   end

   always_comb begin
      rd_data = UNMAPPED_RD;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (addr == 8'(i)) rd_data = regs_flat[8*i +: 8];
      end
   end

endmodule
`default_nettype wire

// File: rtl/qlal3_a2f_responder.sv
`default_nettype none
// ============================================================================
//  Module      : qlal3_a2f_responder
//  Description : Fabric-side target of the EOS S3 A2F register bus. Accepts a
//                4-phase REQ/ACK transaction, optionally inserts wait states,
//                then answers with a one-cycle ACK and registered RD_DATA.
//                Tracks a sticky error flag and a 5-bit transaction counter.
//  Options     : QLAL3_A2F_REQ_SYNC_EN - when defined, A2F_REQ passes through
//                a 2-flop synchronizer (ACK latency grows by two cycles).
//  Ports       : clk, rst  - clock, synchronous active-high reset
//                bus       - A2F bus, slave side
//                regs_flat - all register contents for fabric logic
//  Revision    : 1.0  initial release
// ============================================================================
module qlal3_a2f_responder
   import qlal3_a2f_pkg::*;
#(
   parameter int         NUM_REGS    = 8,
   parameter int         WAIT_CYCLES = 0,
   parameter logic [7:0] UNMAPPED_RD = 8'hEE
) (
   input  logic                  clk,
   input  logic                  rst,
   qlal3_a2f_responder_if.slave  bus,
   output logic [NUM_REGS*8-1:0] regs_flat
);

   state_t                 r_state;
   logic [3:0]             r_wait_cnt;
   logic                   r_rwn;
   logic [7:0]             r_addr;
   logic [7:0]             r_wr_data;
   logic                   r_soft_clr;
   logic                   r_ack;
   logic [7:0]             r_rd_data;
   logic                   r_err;
   logic [TXN_CNT_W-1:0]   r_txn_cnt;

   logic                   w_req;
   logic                   w_wr_en;
   logic [7:0]             w_rd_data;
   logic                   w_unmapped;
   logic                   w_ctrl_unused;

   assign w_ctrl_unused = ^bus.A2F_Control[CTRL_SOFT_CLR_BIT-1:0];

`ifdef QLAL3_A2F_REQ_SYNC_EN
   logic r_req_meta;
   logic r_req_sync;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_req_meta <= 1'b0;
         r_req_sync <= 1'b0;
      end else begin
         r_req_meta <= bus.A2F_REQ;
         r_req_sync <= r_req_meta;
      end
   end

   assign w_req = r_req_sync;
`else
   assign w_req = bus.A2F_REQ;
`endif

   // The write lands on the same edge that raises ACK.
   assign w_wr_en = (r_state == ST_ACK) && !r_rwn;

   qlal3_a2f_regfile #(
      .NUM_REGS    (NUM_REGS),
      .UNMAPPED_RD (UNMAPPED_RD)
   ) u_regfile (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (w_wr_en),
      .addr      (r_addr),
      .wr_data   (r_wr_data),
      .gp_out    (bus.A2F_GP_OUT),
      .rd_data   (w_rd_data),
      .unmapped  (w_unmapped),
      .gp_in     (bus.A2F_GP_IN),
      .regs_flat (regs_flat)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_wait_cnt <= 4'd0;
         r_rwn      <= 1'b0;
         r_addr     <= 8'h00;
         r_wr_data  <= 8'h00;
         r_soft_clr <= 1'b0;
         r_ack      <= 1'b0;
         r_rd_data  <= 8'h00;
         r_err      <= 1'b0;
         r_txn_cnt  <= '0;
      end else begin
         r_ack <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_req) begin
                  // Request fields are frozen here; later changes are ignored.
                  r_rwn      <= bus.A2F_RWn;
                  r_addr     <= bus.A2F_ADDR;
                  r_wr_data  <= bus.A2F_WR_DATA;
                  r_soft_clr <= bus.A2F_Control[CTRL_SOFT_CLR_BIT];
                  if (WAIT_CYCLES > 0) begin
                     r_state    <= ST_WAIT;
                     r_wait_cnt <= 4'(WAIT_CYCLES - 1);
                  end else begin
                     r_state <= ST_ACK;
                  end
               end
            end

            ST_WAIT: begin
               if (!w_req) begin
                  // Initiator gave up before ACK: abort silently, flag it.
                  r_state <= ST_IDLE;
                  r_err   <= 1'b1;
               end else if (r_wait_cnt == 4'd0) begin
                  r_state <= ST_ACK;
               end else begin
                  r_wait_cnt <= r_wait_cnt - 4'd1;
               end
            end

            ST_ACK: begin
               r_ack <= 1'b1;
               if (r_rwn) r_rd_data <= w_rd_data;
               if (r_soft_clr) begin
                  // Soft-clear wins over this transaction's own bookkeeping.
                  r_err     <= 1'b0;
                  r_txn_cnt <= '0;
               end else begin
                  r_txn_cnt <= r_txn_cnt + 1'b1;
                  if (w_unmapped) r_err <= 1'b1;
               end
               r_state <= ST_RELEASE;
            end

            ST_RELEASE: begin
               if (!w_req) r_state <= ST_IDLE;
            end

            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.A2F_ACK     = r_ack;
   assign bus.A2F_RD_DATA = r_rd_data;
   assign bus.A2F_Status  = {(r_state != ST_IDLE), r_err, r_txn_cnt};

endmodule
`default_nettype wire

// File: tb/tb_qlal3_a2f_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_qlal3_a2f_responder
//  Description : Directed bench for qlal3_a2f_responder. Two instances share
//                clk/rst: u_dut0 with no wait states, u_dut3 with three.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_qlal3_a2f_responder;

   logic        clk;
   logic        rst;
   logic [63:0] regs_flat0;
   logic [63:0] regs_flat3;

   int tests_run = 0;
   int tests_failed = 0;

   qlal3_a2f_responder_if bus0 ();
   qlal3_a2f_responder_if bus3 ();

   qlal3_a2f_responder #(.NUM_REGS(8), .WAIT_CYCLES(0), .UNMAPPED_RD(8'hEE)) u_dut0 (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus0),
      .regs_flat (regs_flat0)
   );

   qlal3_a2f_responder #(.NUM_REGS(8), .WAIT_CYCLES(3), .UNMAPPED_RD(8'hEE)) u_dut3 (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus3),
      .regs_flat (regs_flat3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int w, input logic v);
      if (w == 0) bus0.A2F_REQ = v;
      else        bus3.A2F_REQ = v;
   endtask

   task automatic set_fields(input int w, input logic rwn, input logic [7:0] addr,
                             input logic [7:0] data, input logic [7:0] ctrl);
      if (w == 0) begin
         bus0.A2F_RWn = rwn; bus0.A2F_ADDR = addr; bus0.A2F_WR_DATA = data; bus0.A2F_Control = ctrl;
      end else begin
         bus3.A2F_RWn = rwn; bus3.A2F_ADDR = addr; bus3.A2F_WR_DATA = data; bus3.A2F_Control = ctrl;
      end
   endtask

   function automatic logic get_ack(input int w);
      return (w == 0) ? bus0.A2F_ACK : bus3.A2F_ACK;
   endfunction

   function automatic logic [7:0] get_rd(input int w);
      return (w == 0) ? bus0.A2F_RD_DATA : bus3.A2F_RD_DATA;
   endfunction

   function automatic logic [6:0] get_status(input int w);
      return (w == 0) ? bus0.A2F_Status : bus3.A2F_Status;
   endfunction

   // Full 4-phase transaction. lat counts edges from acceptance (1) to the
   // edge after which ACK is seen; 0 means ACK never came.
   task automatic txn(input int w, input logic rwn, input logic [7:0] addr,
                      input logic [7:0] data, input logic [7:0] ctrl,
                      output logic [7:0] rd, output int lat);
      @(negedge clk);
      set_fields(w, rwn, addr, data, ctrl);
      set_req(w, 1'b1);
      lat = 0;
      rd  = 8'hxx;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (get_ack(w)) begin
            lat = i;
            rd  = get_rd(w);
            break;
         end
      end
      set_req(w, 1'b0);
      @(posedge clk); #1;
   endtask

   logic [7:0] rd;
   int         lat;
   int         acks;

   initial begin
      rst = 1'b1;
      set_req(0, 1'b0); set_req(3, 1'b0);
      set_fields(0, 1'b0, 8'h00, 8'h00, 8'h00);
      set_fields(3, 1'b0, 8'h00, 8'h00, 8'h00);
      bus0.A2F_GP_OUT = 8'h00;
      bus3.A2F_GP_OUT = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ack",    64'(bus0.A2F_ACK), 64'd0);
      chk("rst_rd",     64'(bus0.A2F_RD_DATA), 64'h00);
      chk("rst_status", 64'(bus0.A2F_Status), 64'h00);
      chk("rst_regs",   regs_flat0, 64'h0);
      chk("rst_status3",64'(bus3.A2F_Status), 64'h00);
      rst = 1'b0;

      // ---- zero-wait instance: write/read scratch ----
      txn(0, 1'b0, 8'h03, 8'h5A, 8'h00, rd, lat);
      chk("wr3_lat", 64'(lat), 64'd2);
      txn(0, 1'b1, 8'h03, 8'h00, 8'h00, rd, lat);
      chk("rd3_lat", 64'(lat), 64'd2);
      chk("rd3_data", 64'(rd), 64'h5A);
      chk("status_cnt2", 64'(get_status(0)), 64'h02);

      // ---- GP_IN / GP_OUT mirrors ----
      bus0.A2F_GP_OUT = 8'h81;
      txn(0, 1'b0, 8'h00, 8'hC3, 8'h00, rd, lat);
      chk("gp_in", 64'(bus0.A2F_GP_IN), 64'hC3);
      txn(0, 1'b1, 8'h01, 8'h00, 8'h00, rd, lat);
      chk("rd_gp_out", 64'(rd), 64'h81);
      txn(0, 1'b0, 8'h01, 8'hFF, 8'h00, rd, lat);
      txn(0, 1'b1, 8'h01, 8'h00, 8'h00, rd, lat);
      chk("rd_gp_out_ro", 64'(rd), 64'h81);
      chk("status_cnt6", 64'(get_status(0)), 64'h06);

      // ---- unmapped accesses ----
      txn(0, 1'b1, 8'h20, 8'h00, 8'h00, rd, lat);
      chk("unm_rd_lat", 64'(lat), 64'd2);
      chk("unm_rd", 64'(rd), 64'hEE);
      chk("unm_status", 64'(get_status(0)), 64'h27);
      txn(0, 1'b0, 8'h20, 8'h11, 8'h00, rd, lat);
      chk("unm_wr_regs", regs_flat0, 64'h00000000_5A0081C3);
      chk("unm_wr_status", 64'(get_status(0)), 64'h28);

      // ---- soft-clear on a read ----
      txn(0, 1'b1, 8'h03, 8'h00, 8'h80, rd, lat);
      chk("sclr_rd", 64'(rd), 64'h5A);
      chk("sclr_status", 64'(get_status(0)), 64'h00);

      // ---- counter wrap ----
      for (int i = 0; i < 31; i++) txn(0, 1'b0, 8'h02, 8'(i), 8'h00, rd, lat);
      chk("cnt31", 64'(get_status(0)), 64'h1F);
      txn(0, 1'b0, 8'h02, 8'h1F, 8'h00, rd, lat);
      chk("cnt_wrap", 64'(get_status(0)), 64'h00);
      chk("wrap_reg2", 64'(regs_flat0[23:16]), 64'h1F);

      // ---- REQ held high after ACK: no second ACK ----
      @(negedge clk);
      set_fields(0, 1'b1, 8'h02, 8'h00, 8'h00);
      set_req(0, 1'b1);
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (bus0.A2F_ACK) begin lat = i; rd = bus0.A2F_RD_DATA; break; end
      end
      chk("hold_lat", 64'(lat), 64'd2);
      chk("hold_rd", 64'(rd), 64'h1F);
      acks = 0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         if (bus0.A2F_ACK) acks++;
      end
      chk("hold_no_2nd_ack", 64'(acks), 64'd0);
      chk("hold_busy", 64'(get_status(0)), 64'h41);
      set_req(0, 1'b0);
      @(posedge clk); #1;
      chk("hold_release", 64'(get_status(0)), 64'h01);

      // ---- three-wait instance: abort in WAIT ----
      @(negedge clk);
      set_fields(3, 1'b0, 8'h02, 8'h99, 8'h00);
      set_req(3, 1'b1);
      acks = 0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         if (bus3.A2F_ACK) acks++;
      end
      set_req(3, 1'b0);
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (bus3.A2F_ACK) acks++;
      end
      chk("abort_no_ack", 64'(acks), 64'd0);
      chk("abort_status", 64'(get_status(3)), 64'h20);
      chk("abort_no_write", 64'(regs_flat3[23:16]), 64'h00);

      txn(3, 1'b1, 8'h02, 8'h00, 8'h80, rd, lat);
      chk("w3_lat", 64'(lat), 64'd5);
      chk("w3_sclr_rd", 64'(rd), 64'h00);
      chk("w3_sclr_status", 64'(get_status(3)), 64'h00);

      // ---- reset during WAIT of a write ----
      txn(3, 1'b0, 8'h02, 8'h55, 8'h00, rd, lat);
      chk("w3_wr55_lat", 64'(lat), 64'd5);
      chk("w3_wr55_status", 64'(get_status(3)), 64'h01);
      @(negedge clk);
      set_fields(3, 1'b0, 8'h02, 8'h77, 8'h00);
      set_req(3, 1'b1);
      acks = 0;
      @(posedge clk); #1;
      if (bus3.A2F_ACK) acks++;
      @(posedge clk); #1;
      if (bus3.A2F_ACK) acks++;
      rst = 1'b1;
      @(posedge clk); #1;
      if (bus3.A2F_ACK) acks++;
      chk("rst_mid_status", 64'(get_status(3)), 64'h00);
      rst = 1'b0;
      set_req(3, 1'b0);
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (bus3.A2F_ACK) acks++;
      end
      chk("rst_mid_no_ack", 64'(acks), 64'd0);
      txn(3, 1'b1, 8'h02, 8'h00, 8'h00, rd, lat);
      chk("rst_mid_lat", 64'(lat), 64'd5);
      chk("rst_mid_rd2", 64'(rd), 64'h00);
      chk("rst_mid_cnt", 64'(get_status(3)), 64'h01);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
`default_nettype wire
